// File: rtl/gpc_pkg.sv
// gpc_pkg: shared width helpers, column weights and accumulator states for the GPC accumulator.
package gpc_pkg;
    typedef enum logic {IDLE = 1'b0, ACCUM = 1'b1} state_t;

    function automatic int max_sum(input int h0, input int h1, input int h2, input int h3);
        return h0 + 2 * h1 + 4 * h2 + 8 * h3;
    endfunction

    // Never narrower than one bit, so an all-empty configuration still has a sum port.
    function automatic int sum_w(input int h0, input int h1, input int h2, input int h3);
        return (max_sum(h0, h1, h2, h3) < 2) ? 1 : $clog2(max_sum(h0, h1, h2, h3) + 1);
    endfunction

    function automatic int bit_weight(input int i, input int h0, input int h1, input int h2);
        return (i < h0) ? 1 : (i < h0 + h1) ? 2 : (i < h0 + h1 + h2) ? 4 : 8;
    endfunction
endpackage

// File: rtl/gpc_colsum.sv
// gpc_colsum: weighted popcount of up to four packed columns (weights 1, 2, 4, 8).
module gpc_colsum
    import gpc_pkg::*;
#(
    parameter int H0 = 5,
    parameter int H1 = 1,
    parameter int H2 = 2,
    parameter int H3 = 0,
    localparam int SUM_W = sum_w(H0, H1, H2, H3),
    localparam int SRC_W = H0 + H1 + H2 + H3
) (
    input  logic [SRC_W-1:0] i_src,
    output logic [SUM_W-1:0] o_sum
);
    always_comb begin
        o_sum = '0;
        for (int i = 0; i < SRC_W; i++)
            o_sum = o_sum + (i_src[i] ? SUM_W'(bit_weight(i, H0, H1, H2)) : SUM_W'(0));
    end
endmodule

// File: rtl/gpc_accum.sv
// gpc_accum: column-sum beats through a one-deep input stage into a group accumulator
// with a registered, back-pressured result and sticky overflow per group.
module gpc_accum
    import gpc_pkg::*;
#(
    parameter int H0 = 5,
    parameter int H1 = 1,
    parameter int H2 = 2,
    parameter int H3 = 0,
    parameter int ACC_W = 8,
    localparam int SUM_W = sum_w(H0, H1, H2, H3),
    localparam int SRC_W = H0 + H1 + H2 + H3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [SRC_W-1:0] src,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    input  logic             mode,
    output logic [ACC_W-1:0] out_data,
    output logic             out_ovf,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
);
    logic [SUM_W-1:0] w_beat, r_s1_beat;
    logic             r_s1_valid, r_s1_last, r_mode, r_sticky;
    logic [ACC_W-1:0] r_acc, r_out_data, w_acc_in;
    logic             r_out_valid, r_out_ovf;
    logic [ACC_W:0]   w_sum_x;
    logic             w_adv, w_fire, w_grp_open, w_mode, w_ovf;
    state_t           r_state, w_state_nxt;

    gpc_colsum #(.H0(H0), .H1(H1), .H2(H2), .H3(H3)) u_colsum (
        .i_src (src),
        .o_sum (w_beat)
    );

    // A group is open once a non-last beat has been accepted; its captured mode then sticks.
    assign w_grp_open = (r_state == ACCUM) | (r_s1_valid & ~r_s1_last);
    assign w_mode     = w_grp_open ? r_mode : mode;
    assign w_fire     = in_valid & in_ready;
    assign w_acc_in   = (r_state == ACCUM) ? r_acc : '0;
    assign w_sum_x    = {1'b0, w_acc_in} + {1'b0, ACC_W'(r_s1_beat)};
    assign w_ovf      = ((r_state == ACCUM) & r_sticky) | w_sum_x[ACC_W];
    assign out_data   = r_out_data;
    assign out_ovf    = r_out_ovf;
    assign out_valid  = r_out_valid;

    always_comb begin
        w_adv       = r_s1_valid & (~r_out_valid | out_ready);
        in_ready    = ~r_s1_valid | w_adv;
        busy        = (r_state == ACCUM) | r_s1_valid;
        w_state_nxt = w_adv ? (r_s1_last ? IDLE : ACCUM) : r_state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_beat  <= '0;
            r_s1_last  <= 1'b0;
            r_mode     <= 1'b0;
        end else if (w_fire) begin
            r_s1_valid <= 1'b1;
            r_s1_beat  <= w_beat;
            r_s1_last  <= in_last | ~w_mode;
            r_mode     <= w_mode;
        end else if (w_adv) begin
            r_s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc    <= '0;
            r_sticky <= 1'b0;
        end else if (w_adv) begin
            r_acc    <= r_s1_last ? '0 : w_sum_x[ACC_W-1:0];
            r_sticky <= ~r_s1_last & w_ovf;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_ovf   <= 1'b0;
        end else if (w_adv & r_s1_last) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_sum_x[ACC_W-1:0];
            r_out_ovf   <= w_ovf;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_gpc_accum.sv
// tb_gpc_accum: directed vectors for gpc_accum at default columns, plus an ACC_W=4 instance for overflow.
module tb_gpc_accum;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] src;
    logic       in_valid, in_last, in_ready, mode, out_ovf, out_valid, out_ready, busy;
    logic [7:0] out_data;
    logic [7:0] d4_src;
    logic       d4_in_valid, d4_in_last, d4_in_ready, d4_mode, d4_out_ovf, d4_out_valid, d4_out_ready, d4_busy;
    logic [3:0] d4_out_data;
    int         n_vec = 0;
    int         n_err = 0;

    typedef struct {
        logic [7:0] src;
        logic [7:0] exp;
    } vec_t;
    vec_t vt[9];

    always #5 clk = ~clk;

    gpc_accum u_dut (
        .clk (clk), .rst_n (rst_n), .src (src), .in_valid (in_valid), .in_last (in_last),
        .in_ready (in_ready), .mode (mode), .out_data (out_data), .out_ovf (out_ovf),
        .out_valid (out_valid), .out_ready (out_ready), .busy (busy)
    );

    gpc_accum #(.ACC_W(4)) u_dut4 (
        .clk (clk), .rst_n (rst_n), .src (d4_src), .in_valid (d4_in_valid), .in_last (d4_in_last),
        .in_ready (d4_in_ready), .mode (d4_mode), .out_data (d4_out_data), .out_ovf (d4_out_ovf),
        .out_valid (d4_out_valid), .out_ready (d4_out_ready), .busy (d4_busy)
    );

    function automatic int ref_sum(input logic [7:0] s);
        return $countones(s[4:0]) + 2 * int'(s[5]) + 4 * $countones(s[7:6]);
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Present one beat from a negedge and return on the negedge after it is accepted.
    task automatic beat(input logic [7:0] s, input logic m, input logic l);
        int t = 0;
        in_valid = 1'b1;
        src      = s;
        mode     = m;
        in_last  = l;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("beat_ready", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic expect_out(input string nm, input logic [7:0] e_data, input logic e_ovf);
        int t = 0;
        while (!out_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        check({nm, "_valid"}, out_valid, 1);
        check({nm, "_data"}, out_data, e_data);
        check({nm, "_ovf"}, out_ovf, e_ovf);
        @(negedge clk);
        check({nm, "_nodup"}, out_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] s27[20];
        vt[0] = '{8'h74, 8'd8};
        vt[1] = '{8'h00, 8'd0};
        vt[2] = '{8'hFF, 8'd15};
        vt[3] = '{8'h1F, 8'd5};
        vt[4] = '{8'h20, 8'd2};
        vt[5] = '{8'h40, 8'd4};
        vt[6] = '{8'hC0, 8'd8};
        vt[7] = '{8'h01, 8'd1};
        vt[8] = '{8'hCD, 8'd11};
        rst_n = 1'b0; src = '0; in_valid = 0; in_last = 0; mode = 0; out_ready = 1'b1;
        d4_src = '0; d4_in_valid = 0; d4_in_last = 0; d4_mode = 0; d4_out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_ovf", out_ovf, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);

        // Pass mode: result one cycle after acceptance must not be there yet, two cycles later it must.
        foreach (vt[i]) begin
            beat(vt[i].src, 1'b0, 1'b0);
            check($sformatf("pass%0d_lat1", i), out_valid, 0);
            @(negedge clk);
            check($sformatf("pass%0d_valid", i), out_valid, 1);
            check($sformatf("pass%0d_data", i), out_data, vt[i].exp);
            check($sformatf("pass%0d_ovf", i), out_ovf, 0);
            @(negedge clk);
            check($sformatf("pass%0d_clear", i), out_valid, 0);
        end

        // Two-beat accumulate group: 8 + 11.
        beat(8'h74, 1'b1, 1'b0);
        check("acc_busy0", busy, 1);
        @(negedge clk);
        check("acc_busy1", busy, 1);
        check("acc_noout", out_valid, 0);
        beat(8'hCD, 1'b1, 1'b1);
        expect_out("acc19", 8'd19, 1'b0);
        check("acc_idle", busy, 0);

        // Dropping mode mid-group must not terminate the group: 8 + 11 + 1.
        beat(8'h74, 1'b1, 1'b0);
        beat(8'hCD, 1'b0, 1'b0);
        @(negedge clk);
        check("modechg_noout", out_valid, 0);
        check("modechg_busy", busy, 1);
        beat(8'h01, 1'b0, 1'b1);
        expect_out("modechg20", 8'd20, 1'b0);

        // 20 back-to-back pass beats; output for beat i-2 is visible before driving beat i.
        foreach (s27[i]) s27[i] = 8'(i * 37 + 5);
        mode = 1'b0; in_last = 1'b0;
        for (int i = 0; i < 22; i++) begin
            if (i >= 2) begin
                check($sformatf("b2b%0d_valid", i - 2), out_valid, 1);
                check($sformatf("b2b%0d_data", i - 2), out_data, 8'(ref_sum(s27[i - 2])));
            end
            if (i < 20) begin
                in_valid = 1'b1;
                src = s27[i];
                check($sformatf("b2b%0d_ready", i), in_ready, 1);
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end
        check("b2b_drain", out_valid, 0);

        // Back-pressure: two beats accepted, third stalls, output held.
        out_ready = 1'b0;
        in_valid = 1'b1; src = 8'h74;
        check("bp_ready_a", in_ready, 1);
        @(negedge clk);
        src = 8'hCD;
        check("bp_ready_b", in_ready, 1);
        @(negedge clk);
        src = 8'hFF;
        check("bp_ready_c", in_ready, 0);
        check("bp_valid", out_valid, 1);
        check("bp_data", out_data, 8);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("bp_hold_ready%0d", i), in_ready, 0);
            check($sformatf("bp_hold_data%0d", i), out_data, 8);
        end
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("bp_out_b_valid", out_valid, 1);
        check("bp_out_b", out_data, 11);
        @(negedge clk);
        check("bp_out_c_valid", out_valid, 1);
        check("bp_out_c", out_data, 15);
        @(negedge clk);
        check("bp_nodup", out_valid, 0);

        // ACC_W=4 instance: 15 + 15 wraps to 14 with overflow, next group of 3 is clean.
        d4_in_valid = 1'b1; d4_src = 8'hFF; d4_mode = 1'b1; d4_in_last = 1'b0;
        @(negedge clk);
        d4_in_last = 1'b1;
        @(negedge clk);
        d4_in_valid = 1'b0;
        @(negedge clk);
        check("ovf_valid", d4_out_valid, 1);
        check("ovf_data", d4_out_data, 4'd14);
        check("ovf_flag", d4_out_ovf, 1);
        d4_in_valid = 1'b1; d4_src = 8'h07; d4_in_last = 1'b1;
        @(negedge clk);
        d4_in_valid = 1'b0;
        @(negedge clk);
        check("ovf2_valid", d4_out_valid, 1);
        check("ovf2_data", d4_out_data, 4'd3);
        check("ovf2_flag", d4_out_ovf, 0);

        // Reset in the middle of a group discards it.
        beat(8'h74, 1'b1, 1'b0);
        beat(8'h74, 1'b1, 1'b0);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_valid", out_valid, 0);
        check("midrst_data", out_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst_ready", in_ready, 1);
        for (int i = 0; i < 5; i++) begin
            if (i == 4) check("midrst_noout", out_valid, 0);
            beat(8'h01, 1'b1, i == 4);
        end
        expect_out("midrst5", 8'd5, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
